mux_select_sequencer: RTL and testbench
=======================================

MUX_SELECT_SEQUENCER -- requirements
Module: mux_select_sequencer

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1: 1 = drive bit 0 first, 0 = drive bit 7 first.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port Load_Data  input  8  parallel word to serialize.
REQ-005 SHALL have port Load_Valid  input  1  Load_Data is valid.
REQ-006 SHALL have port Load_Ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port Word_Out  output  8  held word; feeds the data input of the downstream 8:1 mux.
REQ-008 SHALL have port Select_Lines  output  3  current bit index; feeds the select input of the downstream 8:1 mux.
REQ-009 SHALL have port Bit_Valid  output  1  downstream mux output is a valid serial bit this cycle.
REQ-010 SHALL have port Bit_Last  output  1  current bit is the final bit of the word.
REQ-011 SHALL have port Bit_Ready  input  1  consumer accepts the current bit.
REQ-012 SHALL have port Busy  output  1  a word is in flight.
REQ-013 SHALL have port Frames_Sent  output  8  count of completed words.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and SEND.
REQ-015 Load accept SHALL occur when Load_Valid and Load_Ready are both high at a rising edge.
REQ-016 On load accept, Load_Data SHALL be registered into Word_Out, Select_Lines SHALL be set to the start index (0 if LSB_FIRST, else 7), and state SHALL become SEND.
REQ-017 Bit_Valid and Busy SHALL be high exactly when state is SEND; both SHALL be registered-state-derived, with no combinational path from Bit_Ready.
REQ-018 Bit accept SHALL occur when Bit_Valid and Bit_Ready are both high; Select_Lines SHALL advance by +1 (LSB_FIRST) or -1 (MSB-first) on each non-final bit accept.
REQ-019 While Bit_Valid is high and Bit_Ready is low, Word_Out, Select_Lines, and Bit_Last SHALL hold; no bit is skipped or duplicated.
REQ-020 Bit_Last SHALL be high in SEND when Select_Lines equals the end index (7 if LSB_FIRST, else 0).
REQ-021 Bit accept with Bit_Last high SHALL increment Frames_Sent modulo 256 (255 -> 0) and SHALL return state to IDLE unless a new load is accepted in the same cycle.
REQ-022 Load_Ready SHALL be high in IDLE, and SHALL also be high in SEND during a cycle with a final bit accept (combinational on Bit_Ready), giving zero-bubble back-to-back words; Load_Ready SHALL be low otherwise.
REQ-023 Simultaneous final bit accept and load accept SHALL load the new word, reset Select_Lines to the start index, and stay in SEND; Frames_Sent SHALL still increment.
REQ-024 Each word SHALL take exactly 8 bit accepts; with Bit_Ready held high, one word SHALL complete every 8 cycles.
REQ-025 Load_Data SHALL be ignored while Load_Ready is low.

Reset
REQ-026 While rst is high at a clock edge: state SHALL be IDLE, and Word_Out=0, Select_Lines=0, Bit_Valid=0, Bit_Last=0, Busy=0, and Frames_Sent=0.
REQ-027 Load_Ready SHALL be low in any cycle where rst is high.
REQ-028 Reset asserted mid-word SHALL abort the word without incrementing Frames_Sent; the first cycle after reset SHALL be IDLE.

Structure
REQ-029 FSM state encoding and constants IDX_FIRST_LSB=0 and IDX_LAST_LSB=7 SHALL live in a shared package, mux_seq_pkg.
REQ-030 The bit-index counter with direction, hold, and reload SHALL be a sub-module, bit_index_counter; the block SHALL contain no mux itself.

Verification
REQ-031 Reset, then load 8'hA5 with LSB_FIRST=1 and Bit_Ready held high: Select_Lines SHALL be 0..7 on 8 consecutive cycles, the mux output SHALL be 1,0,1,0,0,1,0,1, Bit_Last SHALL be high only at index 7, and Frames_Sent SHALL be 1.
REQ-032 With LSB_FIRST=0, load 8'h80: the first bit SHALL be index 7 with value 1, and Bit_Last SHALL be high at index 0.
REQ-033 Load 8'h3C and toggle Bit_Ready 1,0,0,1,...: Select_Lines SHALL hold during low cycles, exactly 8 bits SHALL be accepted, and the result SHALL be 0,0,1,1,1,1,0,0.
REQ-034 Keep Load_Valid high with words 8'h01 then 8'hFF and Bit_Ready held high: the second word's index 0 SHALL follow index 7 with no gap, and Frames_Sent SHALL be 2 after 16 cycles.
REQ-035 Assert rst at index 4: all outputs SHALL be at their reset values the next cycle, and Frames_Sent SHALL stay 0.
REQ-036 Send 256 words back-to-back: Frames_Sent SHALL wrap to 0.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// Shared state encoding and bit-index constants for the mux select sequencer.
package mux_seq_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } seq_state_e;

  localparam logic [2:0] IDX_FIRST_LSB = 3'd0;
  localparam logic [2:0] IDX_LAST_LSB  = 3'd7;

  // MSB-first traversal simply swaps the first and last indices.
  function automatic logic [2:0] start_idx(input bit lsb_first);
    return lsb_first ? IDX_FIRST_LSB : IDX_LAST_LSB;
  endfunction

  function automatic logic [2:0] end_idx(input bit lsb_first);
    return lsb_first ? IDX_LAST_LSB : IDX_FIRST_LSB;
  endfunction

endpackage

// File: rtl/bit_index_counter.sv
// 3-bit index counter with direction, hold and reload; drives the downstream mux select.
module bit_index_counter
  import mux_seq_pkg::*;
#(
  parameter bit LsbFirst = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       reload_i,
  input  logic       advance_i,
  output logic [2:0] idx_o,
  output logic       at_end_o
);

  logic [2:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (reload_i) begin
      idx_d = start_idx(LsbFirst);
    end else if (advance_i) begin
      idx_d = LsbFirst ? idx_q + 3'd1 : idx_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= 3'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o    = idx_q;
  assign at_end_o = (idx_q == end_idx(LsbFirst));

endmodule

// File: rtl/mux_select_sequencer.sv
// Holds a parallel word and steps the select lines of an external 8:1 mux to serialize it.
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Load_Data,
  input  logic       Load_Valid,
  output logic       Load_Ready,
  output logic [7:0] Word_Out,
  output logic [2:0] Select_Lines,
  output logic       Bit_Valid,
  output logic       Bit_Last,
  input  logic       Bit_Ready,
  output logic       Busy,
  output logic [7:0] Frames_Sent
);

  seq_state_e state_q, state_d;
  logic [7:0] word_q, word_d;
  logic [7:0] frames_q, frames_d;
  logic       in_send, at_end, bit_acc, final_acc, load_acc;

  assign in_send   = (state_q == StSend);
  assign bit_acc   = in_send & Bit_Ready;
  assign final_acc = bit_acc & at_end;
  // Final bit accept frees the word register in the same cycle: zero-bubble reload.
  assign Load_Ready = ~rst & (~in_send | final_acc);
  assign load_acc   = Load_Valid & Load_Ready;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    frames_d = frames_q;
    if (final_acc) begin
      frames_d = frames_q + 8'd1;
      state_d  = StIdle;
    end
    if (load_acc) begin
      word_d  = Load_Data;
      state_d = StSend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      word_q   <= 8'd0;
      frames_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      frames_q <= frames_d;
    end
  end

  bit_index_counter #(
    .LsbFirst (LSB_FIRST)
  ) u_idx (
    .clk_i     (clk),
    .rst_i     (rst),
    .reload_i  (load_acc),
    .advance_i (bit_acc & ~at_end),
    .idx_o     (Select_Lines),
    .at_end_o  (at_end)
  );

  assign Word_Out    = word_q;
  assign Bit_Valid   = in_send;
  assign Busy        = in_send;
  assign Bit_Last    = in_send & at_end;
  assign Frames_Sent = frames_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Scoreboard bench: an LSB-first and an MSB-first sequencer, expected bits queued at load.
module tb_mux_select_sequencer;

  typedef struct packed {
    logic [7:0] w;
    logic [2:0] idx;
    logic       val;
    logic       last;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Load_Data, Word_Out, Frames_Sent;
  logic       Load_Valid, Load_Ready, Bit_Valid, Bit_Last, Bit_Ready, Busy;
  logic [2:0] Select_Lines;

  logic [7:0] b_load_data, b_word, b_frames;
  logic       b_load_valid, b_load_ready, b_bit_valid, b_bit_last, b_bit_ready, b_busy;
  logic [2:0] b_sel;

  entry_t     exp_q[$];
  entry_t     b_q[$];
  logic [7:0] exp_frames;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  mux_select_sequencer #(.LSB_FIRST(1'b1)) u_dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .Load_Data    (Load_Data),
    .Load_Valid   (Load_Valid),
    .Load_Ready   (Load_Ready),
    .Word_Out     (Word_Out),
    .Select_Lines (Select_Lines),
    .Bit_Valid    (Bit_Valid),
    .Bit_Last     (Bit_Last),
    .Bit_Ready    (Bit_Ready),
    .Busy         (Busy),
    .Frames_Sent  (Frames_Sent)
  );

  mux_select_sequencer #(.LSB_FIRST(1'b0)) u_dut_msb (
    .clk          (clk),
    .rst          (rst),
    .Load_Data    (b_load_data),
    .Load_Valid   (b_load_valid),
    .Load_Ready   (b_load_ready),
    .Word_Out     (b_word),
    .Select_Lines (b_sel),
    .Bit_Valid    (b_bit_valid),
    .Bit_Last     (b_bit_last),
    .Bit_Ready    (b_bit_ready),
    .Busy         (b_busy),
    .Frames_Sent  (b_frames)
  );

  task automatic push_a(input logic [7:0] w);
    entry_t e;
    for (int i = 0; i < 8; i++) begin
      e.w = w; e.idx = 3'(i); e.val = w[i]; e.last = (i == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_b(input logic [7:0] w);
    entry_t e;
    for (int i = 0; i < 8; i++) begin
      e.w = w; e.idx = 3'(7 - i); e.val = w[7-i]; e.last = (i == 7);
      b_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({Word_Out, Select_Lines, Bit_Valid, Bit_Last, Busy, Frames_Sent} !== 22'd0)
      $display("FAIL reset_lsb: got %h required 0",
               {Word_Out, Select_Lines, Bit_Valid, Bit_Last, Busy, Frames_Sent});
    else n_pass++;
    n_checks++;
    if ({b_word, b_sel, b_bit_valid, b_bit_last, b_busy, b_frames} !== 22'd0)
      $display("FAIL reset_msb: got %h required 0",
               {b_word, b_sel, b_bit_valid, b_bit_last, b_busy, b_frames});
    else n_pass++;
    n_checks++;
    if (Load_Ready !== 1'b0) $display("FAIL ready_in_reset: got %b required 0", Load_Ready);
    else n_pass++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (Load_Ready !== 1'b1) $display("FAIL ready_idle: got %b required 1", Load_Ready);
    else n_pass++;
  endtask

  task automatic test_lsb_a5;
    entry_t e;
    @(posedge clk); #1;
    Load_Data = 8'hA5; Load_Valid = 1'b1; Bit_Ready = 1'b1; push_a(8'hA5);
    @(posedge clk); #1; Load_Valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (!(Bit_Valid && Bit_Ready) || exp_q.size() == 0) begin
        $display("FAIL a5_bit%0d: got valid %b required valid with queued bit", c, Bit_Valid);
      end else begin
        e = exp_q.pop_front();
        if (e.last) exp_frames++;
        if ({Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last} !== e)
          $display("FAIL a5_bit%0d: got %h required %h", c,
                   {Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last}, e);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (Frames_Sent !== 8'd1) $display("FAIL a5_frames: got %0d required 1", Frames_Sent);
    else n_pass++;
    n_checks++;
    if (Busy !== 1'b0) $display("FAIL a5_idle: got busy %b required 0", Busy);
    else n_pass++;
  endtask

  task automatic test_msb_80;
    entry_t e;
    logic [7:0] b_exp_frames = 8'd0;
    @(posedge clk); #1;
    b_load_data = 8'h80; b_load_valid = 1'b1; b_bit_ready = 1'b1; push_b(8'h80);
    @(posedge clk); #1; b_load_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if ({b_sel, b_word[b_sel]} !== 4'b1111)
          $display("FAIL msb_first_bit: got idx %0d val %b required idx 7 val 1",
                   b_sel, b_word[b_sel]);
        else n_pass++;
      end
      n_checks++;
      if (!b_bit_valid || b_q.size() == 0) begin
        $display("FAIL msb_bit%0d: got valid %b required valid with queued bit", c, b_bit_valid);
      end else begin
        e = b_q.pop_front();
        if (e.last) b_exp_frames++;
        if ({b_word, b_sel, b_word[b_sel], b_bit_last} !== e)
          $display("FAIL msb_bit%0d: got %h required %h", c,
                   {b_word, b_sel, b_word[b_sel], b_bit_last}, e);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (b_frames !== b_exp_frames)
      $display("FAIL msb_frames: got %0d required %0d", b_frames, b_exp_frames);
    else n_pass++;
  endtask

  task automatic test_stall_3c;
    entry_t e;
    int acc = 0;
    logic [2:0] prev_idx = 3'd0;
    logic prev_rdy = 1'b1;
    @(posedge clk); #1;
    Load_Data = 8'h3C; Load_Valid = 1'b1; Bit_Ready = 1'b0; push_a(8'h3C);
    @(posedge clk); #1; Load_Valid = 1'b0; Bit_Ready = 1'b1;
    for (int c = 0; c < 40 && acc < 8; c++) begin
      @(negedge clk);
      if (!prev_rdy) begin
        n_checks++;
        if (Select_Lines !== prev_idx || Bit_Valid !== 1'b1)
          $display("FAIL stall_hold%0d: got idx %0d valid %b required idx %0d valid 1",
                   c, Select_Lines, Bit_Valid, prev_idx);
        else n_pass++;
      end
      if (Bit_Ready) begin
        n_checks++;
        if (!Bit_Valid || exp_q.size() == 0) begin
          $display("FAIL stall_bit%0d: got valid %b required valid with queued bit", acc, Bit_Valid);
        end else begin
          e = exp_q.pop_front();
          if (e.last) exp_frames++;
          if ({Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last} !== e)
            $display("FAIL stall_bit%0d: got %h required %h", acc,
                     {Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last}, e);
          else n_pass++;
        end
        acc++;
      end
      prev_idx = Select_Lines;
      prev_rdy = Bit_Ready;
      @(posedge clk); #1;
      Bit_Ready = ((c + 1) % 4 == 0) || ((c + 1) % 4 == 3);
    end
    Bit_Ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (acc !== 8 || Busy !== 1'b0 || Frames_Sent !== exp_frames)
      $display("FAIL stall_done: got %0d bits busy %b frames %0d required 8 bits busy 0 frames %0d",
               acc, Busy, Frames_Sent, exp_frames);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    entry_t e;
    @(posedge clk); #1;
    Load_Data = 8'h01; Load_Valid = 1'b1; Bit_Ready = 1'b1; push_a(8'h01);
    @(posedge clk); #1;
    Load_Data = 8'hFF; push_a(8'hFF);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 7) begin
        n_checks++;
        if (Load_Ready !== 1'b1) $display("FAIL b2b_ready: got %b required 1", Load_Ready);
        else n_pass++;
      end
      n_checks++;
      if (!Bit_Valid || exp_q.size() == 0) begin
        $display("FAIL b2b_bit%0d: got valid %b required valid with queued bit", c, Bit_Valid);
      end else begin
        e = exp_q.pop_front();
        if (e.last) exp_frames++;
        if ({Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last} !== e)
          $display("FAIL b2b_bit%0d: got %h required %h", c,
                   {Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last}, e);
        else n_pass++;
      end
      @(posedge clk); #1;
      if (c == 7) Load_Valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (Frames_Sent !== exp_frames || Busy !== 1'b0)
      $display("FAIL b2b_frames: got %0d busy %b required %0d busy 0",
               Frames_Sent, Busy, exp_frames);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    entry_t e;
    @(posedge clk); #1;
    Load_Data = 8'h5A; Load_Valid = 1'b1; Bit_Ready = 1'b1; push_a(8'h5A);
    @(posedge clk); #1; Load_Valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      e = exp_q.pop_front();
      if ({Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last} !== e)
        $display("FAIL mid_bit%0d: got %h required %h", c,
                 {Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last}, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (Select_Lines !== 3'd4) $display("FAIL mid_idx: got %0d required 4", Select_Lines);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (Load_Ready !== 1'b0) $display("FAIL mid_ready_rst: got %b required 0", Load_Ready);
    else n_pass++;
    @(posedge clk); #1; rst = 1'b0;
    exp_q.delete();
    exp_frames = 8'd0;
    @(negedge clk);
    n_checks++;
    if ({Word_Out, Select_Lines, Bit_Valid, Bit_Last, Busy, Frames_Sent} !== 22'd0)
      $display("FAIL mid_reset: got %h required 0",
               {Word_Out, Select_Lines, Bit_Valid, Bit_Last, Busy, Frames_Sent});
    else n_pass++;
  endtask

  task automatic test_wrap;
    entry_t e;
    int pushed = 0;
    int errs = 0;
    int bits = 0;
    @(posedge clk); #1;
    Load_Data = 8'($urandom); Load_Valid = 1'b1; Bit_Ready = 1'b1;
    for (int c = 0; c < 2300 && !(pushed == 256 && exp_q.size() == 0); c++) begin
      @(negedge clk);
      if (Frames_Sent !== exp_frames) begin
        if (errs < 4) $display("FAIL wrap_frames%0d: got %0d required %0d", c, Frames_Sent, exp_frames);
        errs++;
      end
      if (Bit_Valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        bits++;
        if (e.last) exp_frames++;
        if ({Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last} !== e) begin
          if (errs < 4) $display("FAIL wrap_bit%0d: got %h required %h", c,
                                 {Word_Out, Select_Lines, Word_Out[Select_Lines], Bit_Last}, e);
          errs++;
        end
      end else if (Bit_Valid || pushed != 0) begin
        if (errs < 4) $display("FAIL wrap_gap%0d: got valid %b with %0d queued", c,
                               Bit_Valid, exp_q.size());
        errs++;
      end
      if (Load_Valid && Load_Ready) begin
        push_a(Load_Data);
        pushed++;
      end
      @(posedge clk); #1;
      if (pushed == 256) Load_Valid = 1'b0;
      else Load_Data = 8'($urandom);
    end
    n_checks++;
    if (errs != 0 || bits != 2048)
      $display("FAIL wrap_stream: got %0d errors %0d bits required 0 errors 2048 bits", errs, bits);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (Frames_Sent !== 8'd0 || Busy !== 1'b0)
      $display("FAIL wrap_zero: got frames %0d busy %b required 0 busy 0", Frames_Sent, Busy);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    Load_Data = 8'd0; Load_Valid = 1'b0; Bit_Ready = 1'b0;
    b_load_data = 8'd0; b_load_valid = 1'b0; b_bit_ready = 1'b0;
    exp_frames = 8'd0;
    test_reset();
    test_lsb_a5();
    test_msb_80();
    test_stall_3c();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
